// File: rtl/instr_encoder_pkg.sv
// Shared types and constants for the immediate instruction encoder.
// Holds format encodings, FSM states, range limits and the field packer.
package instr_encoder_pkg;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_X = 2'b11
  } imm_src_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ENCODE = 2'b01,
    OUT    = 2'b10
  } state_e;

  localparam int signed IS_MIN = -2048;
  localparam int signed IS_MAX = 2047;
  localparam int signed B_MIN  = -4096;
  localparam int signed B_MAX  = 4094;

  typedef struct packed {
    logic [1:0]  src;
    logic [31:0] imm;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } req_t;

  function automatic logic [31:0] pack_instr(req_t r);
    logic [31:0] w;
    w = '0;
    unique case (1'b1)
      r.src == IMM_I:
        w = {r.imm[11:0], r.rs1, r.f3, r.rd, r.op};
      r.src == IMM_S:
        w = {r.imm[11:5], r.rs2, r.rs1,
             r.f3, r.imm[4:0], r.op};
      r.src == IMM_B:
        w = {r.imm[12], r.imm[10:5], r.rs2,
             r.rs1, r.f3, r.imm[4:1],
             r.imm[11], r.op};
      default:
        w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/imm_range_check.sv
// Combinational legality check of an immediate for its format.
// B immediates must also be even.
module imm_range_check
  import instr_encoder_pkg::*;
(
  input  logic [1:0]  ImmSrc,
  input  logic [31:0] Imm,
  output logic        Ok
);

  logic signed [31:0] simm;

  assign simm = Imm;

  always_comb begin
    Ok = 1'b0;
    unique case (1'b1)
      ImmSrc == IMM_I,
      ImmSrc == IMM_S:
        Ok = (simm >= IS_MIN) && (simm <= IS_MAX);
      ImmSrc == IMM_B:
        Ok = (simm >= B_MIN) && (simm <= B_MAX)
             && !Imm[0];
      default:
        Ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Three-state encoder: capture request, check and pack, then hold
// the result until the consumer takes it. Counters saturate.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [1:0]       ImmSrc,
  input  logic [31:0]      Imm,
  input  logic [6:0]       Opcode,
  input  logic [2:0]       Funct3,
  input  logic [4:0]       Rd,
  input  logic [4:0]       Rs1,
  input  logic [4:0]       Rs2,
  output logic [31:0]      Instr,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic             Err,
  output logic [CNT_W-1:0] Enc_Cnt,
  output logic [CNT_W-1:0] Err_Cnt
);

  state_e state;
  req_t   req;
  logic   ok;

  imm_range_check u_chk (
    .ImmSrc (req.src),
    .Imm    (req.imm),
    .Ok     (ok)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      req       <= '0;
      In_Ready  <= 1'b1;
      Out_Valid <= 1'b0;
      Err       <= 1'b0;
      Instr     <= '0;
      Enc_Cnt   <= '0;
      Err_Cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (In_Valid) begin
            req <= '{src: ImmSrc, imm: Imm,
                     op: Opcode, f3: Funct3,
                     rd: Rd, rs1: Rs1, rs2: Rs2};
            In_Ready <= 1'b0;
            state    <= ENCODE;
          end
        end
        ENCODE: begin
          Instr     <= ok ? pack_instr(req) : '0;
          Err       <= !ok;
          Out_Valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (Out_Ready) begin
            Out_Valid <= 1'b0;
            In_Ready  <= 1'b1;
            state     <= IDLE;
            if (Enc_Cnt != '1)
              Enc_Cnt <= Enc_Cnt + CNT_W'(1);
            if (Err && (Err_Cnt != '1))
              Err_Cnt <= Err_Cnt + CNT_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          In_Ready  <= 1'b1;
          Out_Valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the width of the statistics counters.
REQ-002 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1: asynchronous, active-low reset.
REQ-004 Port In_Valid, input, 1: the request fields are valid.
REQ-005 Port In_Ready, output, 1: the block accepts a request this cycle.
REQ-006 Port ImmSrc, input, 2: format select; 00 is I, 01 is S, 10 is B, 11 is illegal.
REQ-007 Port Imm, input, 32: signed immediate, two's complement.
REQ-008 Port Opcode, input, 7; Funct3, input, 3; Rd, Rs1 and Rs2, input, 5 each: instruction fields.
REQ-009 Port Instr, output, 32: encoded instruction word.
REQ-010 Port Out_Valid, output, 1; Out_Ready, input, 1: output handshake.
REQ-011 Port Err, output, 1: the presented Instr is rejected; qualified by Out_Valid.
REQ-012 Port Enc_Cnt and Err_Cnt, output, CNT_W each: saturating counts of completed outputs and of rejected outputs.

Function
REQ-013 The FSM SHALL have three states: IDLE, ENCODE and OUT; In_Ready SHALL be 1 only in IDLE.
REQ-014 An accept SHALL occur when In_Valid=1 and In_Ready=1; all input fields SHALL be registered on that edge, and the state SHALL go from IDLE to ENCODE.
REQ-015 ENCODE SHALL last exactly one cycle: registered range check and field packing, then go to OUT.
REQ-016 Out_Valid SHALL be 1 in OUT only; it SHALL rise on the second rising edge after the accept edge.
REQ-017 In OUT, Instr and Err SHALL stay stable until Out_Ready=1; the handshake edge SHALL return the FSM to IDLE.
REQ-018 Inputs SHALL be ignored outside IDLE; Out_Ready SHALL be ignored outside OUT.
REQ-019 I format SHALL pack {Imm[11:0], Rs1, Funct3, Rd, Opcode}; Rs2 is ignored.
REQ-020 S format SHALL pack {Imm[11:5], Rs2, Rs1, Funct3, Imm[4:0], Opcode}; Rd is ignored.
REQ-021 B format SHALL pack {Imm[12], Imm[10:5], Rs2, Rs1, Funct3, Imm[4:1], Imm[11], Opcode}; Rd is ignored.
REQ-022 For I and S, Imm outside -2048..2047 SHALL be rejected.
REQ-023 For B, Imm outside -4096..4094 or Imm[0]=1 SHALL be rejected.
REQ-024 ImmSrc=11 SHALL be rejected.
REQ-025 A rejected request SHALL still complete the handshake, with Instr=0 and Err=1.
REQ-026 An accepted request SHALL produce Err=0.
REQ-027 Enc_Cnt SHALL increment by 1 on each output handshake and hold at all-ones.
REQ-028 Err_Cnt SHALL increment by 1 on each output handshake with Err=1 and hold at all-ones.

Reset
REQ-029 While rst=0: state IDLE, In_Ready=1, Out_Valid=0, Err=0, Instr=0, Enc_Cnt=0, Err_Cnt=0.
REQ-030 Reset asserted in ENCODE or OUT SHALL abort the transaction; no counter SHALL update.
REQ-031 Reset release SHALL resume from IDLE on the first clk edge after release.

Structure
REQ-032 A shared package SHALL hold the ImmSrc encodings (IMM_I, IMM_S, IMM_B), the FSM state enum and the range limits (I/S: -2048 and 2047; B: -4096 and 4094).
REQ-033 The range check SHALL be a combinational sub-module, imm_range_check, with inputs ImmSrc and Imm and output Ok.
REQ-034 All outputs SHALL be driven from registers.

Verification
REQ-035 I accept, with ImmSrc=00, Imm=0xFFFFFFFF, Rd=1, Rs1=0, Funct3=0, Opcode=0x13: Instr=0xFFF00093 and Err=0, two edges after the accept.
REQ-036 S accept, with ImmSrc=01, Imm=8, Rs2=2, Rs1=3, Funct3=2, Opcode=0x23: Instr=0x0021A423.
REQ-037 B accept, with ImmSrc=10, Imm=-4, Rs1=1, Rs2=2, Funct3=0, Opcode=0x63: Instr=0xFE208EE3.
REQ-038 Reject cases, Imm=2048 with ImmSrc=00, Imm=3 with ImmSrc=10, and ImmSrc=11: each gives Instr=0 and Err=1; after the three handshakes, Err_Cnt=3 and Enc_Cnt=3.
REQ-039 Backpressure, with Out_Ready=0 for 5 cycles in OUT: Instr and Err stay stable, In_Ready=0, and a new In_Valid is ignored; on Out_Ready=1, one handshake occurs and In_Ready=1 on the next cycle.
REQ-040 Reset pulse while in OUT: all outputs take the REQ-029 values, counters stay unchanged at 0, and a subsequent request encodes correctly.
